// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Number of address bits needed to select one of nregs registers (at least 1).
  function automatic int calc_aw(input int nregs);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < nregs) w = i + 1;
    end
    return w;
  endfunction

  localparam int AW_DEFAULT = calc_aw(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks which registers have an outstanding producer
// and keeps a registered count of them.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NWR   = 2,
  localparam int AW   = calc_aw(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy,
  output logic [AW:0]       pending_cnt
);

  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;

  // Next busy vector: writes clear, an issue overrides a write, flush overrides everything.
  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
        busy_next[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (issue_en && (issue_addr != '0)) begin
      busy_next[issue_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[r]};
    end
  end

  // Register the busy bits and their population count together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_next;
      pending_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with optional write-to-read forwarding and a
// busy-bit scoreboard. Register 0 is hardwired to zero and never busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  input  logic                flush,
  output logic [AW:0]         pending_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS(NREGS),
    .NWR  (NWR)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .pending_cnt(pending_cnt)
  );

  // Data array update; ports are applied in ascending order so the highest port wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy_bit;

    assign addr = rd_addr[i*AW +: AW];

    // Combinational read with forwarding; a forwarded value is only busy if re-issued now.
    always_comb begin
      data     = regs[addr];
      busy_bit = busy[addr];
      if ((BYPASS != 0) && !reset) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
            data     = wr_data[p*XLEN +: XLEN];
            busy_bit = issue_en && (issue_addr == addr);
          end
        end
      end
      if (addr == '0) begin
        data     = '0;
        busy_bit = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busy_bit;
  end

endmodule
